double_sub_arbiter: RTL and testbench

Shares one `double_sub` pipelined FP64 subtractor among `NUM_REQ` requesters. Each cycle a round-robin scheduler picks one valid request and issues it to the subtractor, whose ports are brought out of this block. A tag pipeline matched to the subtractor latency routes each result back to its requester with a requester ID. The block also checks that the subtractor's result valid lines up with the issue history.

---
 rtl/double_sub_pkg.sv | 22 ++
 rtl/double_sub_rr_pick.sv | 33 +++
 rtl/double_sub_arbiter.sv | 125 ++++++++++++
 tb/tb_double_sub_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/double_sub_pkg.sv
// Shared types and helpers for the arbiter that time-shares one pipelined FP64 subtractor.
package double_sub_pkg;

   localparam int FP_W     = 64;
   localparam int TAG_ID_W = 3;

   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } sub_tag_t;

   // Round-robin successor: the requester after ptr, wrapping at n.
   function automatic logic [TAG_ID_W-1:0] rr_next(input logic [TAG_ID_W-1:0] ptr, input int n);
      logic [TAG_ID_W:0] nxt;
      nxt = {1'b0, ptr} + {{TAG_ID_W{1'b0}}, 1'b1};
      if (int'(nxt) >= n) begin
         nxt = '0;
      end
      return nxt[TAG_ID_W-1:0];
   endfunction

endpackage

// File: rtl/double_sub_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, as one-hot and index.
module double_sub_rr_pick
   import double_sub_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
)
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id
);

   logic [ID_W-1:0] sel;
   logic            found;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      sel    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sel = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[sel]) begin
            found    = 1'b1;
            gnt[sel] = 1'b1;
            gnt_id   = sel;
         end
      end
   end

endmodule

// File: rtl/double_sub_arbiter.sv
// Shares one external pipelined FP64 subtractor among NUM_REQ requesters with round-robin issue,
// a tag pipe that routes results back by requester ID, and a sticky result-valid consistency check.
module double_sub_arbiter
   import double_sub_pkg::*;
#(
   parameter int  NUM_REQ        = 4,
   parameter int  OUTPUT_LATENCY = 1,
   parameter int  ID_W           = $clog2(NUM_REQ),
   localparam int INF_W          = $clog2(OUTPUT_LATENCY + 3)
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*FP_W-1:0] req_a,
   input  logic [NUM_REQ*FP_W-1:0] req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    sub_a_tvalid,
   output logic                    sub_b_tvalid,
   output logic [FP_W-1:0]         sub_a_tdata,
   output logic [FP_W-1:0]         sub_b_tdata,
   input  logic                    sub_result_tvalid,
   input  logic [FP_W-1:0]         sub_result_tdata,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [FP_W-1:0]         rsp_data,
   output logic [INF_W-1:0]        inflight,
   output logic                    err
);

   localparam int                 DRAIN_W    = $clog2(OUTPUT_LATENCY + 2);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(OUTPUT_LATENCY + 1);
   localparam int                 LAST       = OUTPUT_LATENCY - 1;

   logic [ID_W-1:0]    ptr;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_id;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               drain_done;
   logic               accept;
   logic [ID_W-1:0]    issue_id;
   sub_tag_t           tag_pipe [OUTPUT_LATENCY];

   double_sub_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req    (req_valid),
      .ptr    (ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign drain_done   = (drain_cnt == '0);
   assign req_ready    = (enable && drain_done) ? gnt : '0;
   assign accept       = |(req_valid & req_ready);
   assign sub_b_tvalid = sub_a_tvalid;

   // The subtractor has no reset, so hold off grants and the check until its pipe has flushed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_cnt <= DRAIN_LOAD;
      end else if (!drain_done) begin
         drain_cnt <= drain_cnt - DRAIN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr          <= '0;
         issue_id     <= '0;
         sub_a_tvalid <= 1'b0;
         sub_a_tdata  <= '0;
         sub_b_tdata  <= '0;
      end else begin
         sub_a_tvalid <= accept;
         if (accept) begin
            ptr         <= ID_W'(rr_next(TAG_ID_W'(gnt_id), NUM_REQ));
            issue_id    <= gnt_id;
            sub_a_tdata <= req_a[int'(gnt_id)*FP_W +: FP_W];
            sub_b_tdata <= req_b[int'(gnt_id)*FP_W +: FP_W];
         end
      end
   end

   // Stage 0 follows the issue register, so the last stage lines up with sub_result_tvalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < OUTPUT_LATENCY; s++) begin
            tag_pipe[s] <= '0;
         end
      end else begin
         tag_pipe[0] <= '{vld: sub_a_tvalid, id: TAG_ID_W'(issue_id)};
         for (int s = 1; s < OUTPUT_LATENCY; s++) begin
            tag_pipe[s] <= tag_pipe[s-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         inflight  <= '0;
         err       <= 1'b0;
      end else begin
         rsp_valid <= tag_pipe[LAST].vld;
         if (tag_pipe[LAST].vld) begin
            rsp_id   <= tag_pipe[LAST].id[ID_W-1:0];
            rsp_data <= sub_result_tdata;
         end
         if (accept && !tag_pipe[LAST].vld) begin
            inflight <= inflight + INF_W'(1);
         end else if (!accept && tag_pipe[LAST].vld) begin
            inflight <= inflight - INF_W'(1);
         end
         if (drain_done && (tag_pipe[LAST].vld != sub_result_tvalid)) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_double_sub_arbiter.sv
// Bench for double_sub_arbiter: behavioural subtractor model, grant/response scoreboard,
// a table of grant-order vectors and randomized traffic.
module tb_double_sub_arbiter;
   import double_sub_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int L       = 2;
   localparam int ID_W    = $clog2(NUM_REQ);
   localparam int INF_W   = $clog2(L + 3);
   localparam int NTBL    = 27;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    enable = 1'b0;
   logic [NUM_REQ-1:0]      req_valid = '0;
   logic [NUM_REQ*64-1:0]   req_a = '0;
   logic [NUM_REQ*64-1:0]   req_b = '0;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    sub_a_tvalid, sub_b_tvalid;
   logic [63:0]             sub_a_tdata, sub_b_tdata;
   logic                    sub_result_tvalid;
   logic [63:0]             sub_result_tdata;
   logic                    rsp_valid;
   logic [ID_W-1:0]         rsp_id;
   logic [63:0]             rsp_data;
   logic [INF_W-1:0]        inflight;
   logic                    err;

   double_sub_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .OUTPUT_LATENCY (L)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable            (enable),
      .req_valid         (req_valid),
      .req_a             (req_a),
      .req_b             (req_b),
      .req_ready         (req_ready),
      .sub_a_tvalid      (sub_a_tvalid),
      .sub_b_tvalid      (sub_b_tvalid),
      .sub_a_tdata       (sub_a_tdata),
      .sub_b_tdata       (sub_b_tdata),
      .sub_result_tvalid (sub_result_tvalid),
      .sub_result_tdata  (sub_result_tdata),
      .rsp_valid         (rsp_valid),
      .rsp_id            (rsp_id),
      .rsp_data          (rsp_data),
      .inflight          (inflight),
      .err               (err)
   );

   always #5 clk = ~clk;

   // Subtractor model: no reset, fixed latency L, optional spurious valid injection.
   logic        pipe_v [L];
   logic [63:0] pipe_d [L];
   logic        inject = 1'b0;

   function automatic logic [63:0] sub64(input logic [63:0] a, input logic [63:0] b);
      return $realtobits($bitstoreal(a) - $bitstoreal(b));
   endfunction

   always @(posedge clk) begin
      pipe_v[0] <= sub_a_tvalid;
      pipe_d[0] <= sub64(sub_a_tdata, sub_b_tdata);
      for (int k = 1; k < L; k++) begin
         pipe_v[k] <= pipe_v[k-1];
         pipe_d[k] <= pipe_d[k-1];
      end
   end

   assign sub_result_tvalid = pipe_v[L-1] | inject;
   assign sub_result_tdata  = pipe_d[L-1];

   typedef struct {
      int          due;
      int          id;
      logic [63:0] data;
   } rsp_t;

   typedef struct {
      logic               en;
      logic [NUM_REQ-1:0] vld;
      logic [NUM_REQ-1:0] rdy;
   } vec_t;

   rsp_t        exp_q [$];
   vec_t        tbl [NTBL];
   logic        valid_q [NUM_REQ];
   logic [63:0] hold_a [NUM_REQ];
   logic [63:0] hold_b [NUM_REQ];
   int          serial [NUM_REQ];
   logic        cur_en;
   int          m_ptr, m_drain, m_inflight, max_inflight, cyc;
   logic        m_err, m_sub_v;
   logic [63:0] m_sub_a, m_sub_b;
   int          n_checks = 0;
   int          n_fail = 0;

   logic [NUM_REQ-1:0] last_rdy;
   logic               last_rsp_valid, last_err;
   logic [ID_W-1:0]    last_rsp_id;
   logic [63:0]        last_rsp_data;

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic modelReset();
      m_ptr      = 0;
      m_drain    = L + 1;
      m_inflight = 0;
      m_err      = 1'b0;
      m_sub_v    = 1'b0;
      m_sub_a    = '0;
      m_sub_b    = '0;
      exp_q.delete();
   endtask

   // Expected winner this cycle from the round-robin rule, or -1.
   function automatic int modelGrant();
      int i;
      if (!rst_n || !cur_en || m_drain != 0) return -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         i = (m_ptr + k) % NUM_REQ;
         if (valid_q[i]) return i;
      end
      return -1;
   endfunction

   task automatic applyStimulus();
      enable = cur_en;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]       = valid_q[i];
         req_a[i*64 +: 64]  = hold_a[i];
         req_b[i*64 +: 64]  = hold_b[i];
      end
   endtask

   task automatic checkOutput();
      int                 g;
      logic [NUM_REQ-1:0] exp_rdy;
      rsp_t               r;
      g       = modelGrant();
      exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
      last_rdy       = req_ready;
      last_rsp_valid = rsp_valid;
      last_rsp_id    = rsp_id;
      last_rsp_data  = rsp_data;
      last_err       = err;
      checkValue("req_ready", 64'(req_ready), 64'(exp_rdy));
      checkValue("sub_a_tvalid", 64'(sub_a_tvalid), 64'(m_sub_v));
      checkValue("sub_b_tvalid", 64'(sub_b_tvalid), 64'(m_sub_v));
      checkValue("sub_a_tdata", sub_a_tdata, m_sub_a);
      checkValue("sub_b_tdata", sub_b_tdata, m_sub_b);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         r = exp_q.pop_front();
         m_inflight--;
         checkValue("rsp_valid", 64'(rsp_valid), 64'd1);
         checkValue("rsp_id", 64'(rsp_id), 64'(r.id));
         checkValue("rsp_data", rsp_data, r.data);
      end else begin
         checkValue("rsp_valid_idle", 64'(rsp_valid), 64'd0);
      end
      if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
      checkValue("inflight", 64'(inflight), 64'(m_inflight));
      checkValue("err", 64'(err), 64'(m_err));
   endtask

   task automatic advance();
      int g;
      g = modelGrant();
      if (g >= 0) begin
         exp_q.push_back('{due: cyc + L + 2, id: g, data: sub64(hold_a[g], hold_b[g])});
         m_inflight++;
         m_sub_v    = 1'b1;
         m_sub_a    = hold_a[g];
         m_sub_b    = hold_b[g];
         m_ptr      = (g + 1) % NUM_REQ;
         valid_q[g] = 1'b0;
         serial[g]++;
      end else begin
         m_sub_v = 1'b0;
      end
      if (inject && rst_n && m_drain == 0) m_err = 1'b1;
      if (rst_n && m_drain > 0) m_drain--;
      @(posedge clk);
      cyc++;
      #1;
      applyStimulus();
   endtask

   task automatic step();
      @(negedge clk);
      checkOutput();
      advance();
   endtask

   function automatic logic [63:0] opA(input int i);
      return $realtobits(real'(serial[i] * 4 + i + 2));
   endfunction

   function automatic logic [63:0] opB(input int i);
      return $realtobits(real'(i) * 0.5 + 0.25);
   endfunction

   function automatic logic [63:0] randOp();
      return $realtobits((real'($urandom_range(0, 4000)) - 2000.0) / 16.0);
   endfunction

   initial begin
      int blocked, acc_edge;
      logic got;

      // Grant-order vectors; entry 0 starts with ptr at 1.
      tbl[0]  = '{1'b1, 4'b0000, 4'b0000};
      tbl[1]  = '{1'b1, 4'b1111, 4'b0010};
      tbl[2]  = '{1'b1, 4'b1111, 4'b0100};
      tbl[3]  = '{1'b1, 4'b1111, 4'b1000};
      tbl[4]  = '{1'b1, 4'b1111, 4'b0001};
      tbl[5]  = '{1'b1, 4'b1111, 4'b0010};
      tbl[6]  = '{1'b1, 4'b1111, 4'b0100};
      tbl[7]  = '{1'b1, 4'b1111, 4'b1000};
      tbl[8]  = '{1'b1, 4'b0111, 4'b0001};
      tbl[9]  = '{1'b1, 4'b0110, 4'b0010};
      tbl[10] = '{1'b1, 4'b0100, 4'b0100};
      tbl[11] = '{1'b1, 4'b0001, 4'b0001};
      tbl[12] = '{1'b1, 4'b0010, 4'b0010};
      tbl[13] = '{1'b1, 4'b1010, 4'b1000};
      tbl[14] = '{1'b1, 4'b1010, 4'b0010};
      tbl[15] = '{1'b1, 4'b1010, 4'b1000};
      tbl[16] = '{1'b1, 4'b0010, 4'b0010};
      tbl[17] = '{1'b0, 4'b0100, 4'b0000};
      tbl[18] = '{1'b0, 4'b0100, 4'b0000};
      tbl[19] = '{1'b0, 4'b0100, 4'b0000};
      tbl[20] = '{1'b0, 4'b0100, 4'b0000};
      tbl[21] = '{1'b0, 4'b0100, 4'b0000};
      tbl[22] = '{1'b1, 4'b0100, 4'b0100};
      tbl[23] = '{1'b1, 4'b0000, 4'b0000};
      tbl[24] = '{1'b1, 4'b0000, 4'b0000};
      tbl[25] = '{1'b1, 4'b0000, 4'b0000};
      tbl[26] = '{1'b1, 4'b0000, 4'b0000};

      cyc          = 0;
      max_inflight = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         valid_q[i] = 1'b0;
         hold_a[i]  = '0;
         hold_b[i]  = '0;
         serial[i]  = 0;
      end
      modelReset();

      // Reset with a pending request: nothing may be granted, then drain blocks L+1 cycles.
      $display("[TB] reset, drain and single operation");
      hold_a[0]  = 64'h4008000000000000;
      hold_b[0]  = 64'h3FF0000000000000;
      valid_q[0] = 1'b1;
      cur_en     = 1'b1;
      applyStimulus();
      repeat (3) step();
      rst_n   = 1'b1;
      m_drain = L + 1;
      blocked = 0;
      got     = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
         step();
         if (last_rdy != '0) got = 1'b1;
         else blocked++;
      end
      acc_edge = cyc;
      checkValue("drain_blocked_cycles", 64'(blocked), 64'(L + 1));
      checkValue("first_grant", 64'(last_rdy), 64'b0001);
      repeat (L + 2) step();
      checkValue("single_rsp_valid", 64'(last_rsp_valid), 64'd1);
      checkValue("single_rsp_id", 64'(last_rsp_id), 64'd0);
      checkValue("single_rsp_data", last_rsp_data, 64'h4000000000000000);
      checkValue("single_rsp_cycle", 64'(cyc - 1 - acc_edge), 64'(L + 1));

      $display("[TB] grant-order table");
      for (int k = 0; k < NTBL; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            valid_q[i] = tbl[k].vld[i];
            hold_a[i]  = opA(i);
            hold_b[i]  = opB(i);
         end
         cur_en = tbl[k].en;
         applyStimulus();
         step();
         checkValue($sformatf("tbl_ready[%0d]", k), 64'(last_rdy), 64'(tbl[k].rdy));
      end
      checkValue("max_inflight", 64'(max_inflight), 64'(L + 1));

      $display("[TB] random traffic");
      for (int t = 0; t < 300; t++) begin
         cur_en = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_q[i] && $urandom_range(0, 1) == 1) begin
               valid_q[i] = 1'b1;
               hold_a[i]  = randOp();
               hold_b[i]  = randOp();
            end
         end
         applyStimulus();
         step();
      end
      for (int i = 0; i < NUM_REQ; i++) valid_q[i] = 1'b0;
      applyStimulus();
      repeat (L + 3) step();
      checkValue("random_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] spurious result valid");
      inject = 1'b1;
      step();
      inject = 1'b0;
      repeat (3) step();
      checkValue("err_sticky", 64'(last_err), 64'd1);
      checkValue("no_rsp_on_inject", 64'(last_rsp_valid), 64'd0);

      $display("[TB] reset with operations in flight");
      for (int i = 0; i < 2; i++) begin
         valid_q[i] = 1'b1;
         hold_a[i]  = randOp();
         hold_b[i]  = randOp();
      end
      cur_en = 1'b1;
      applyStimulus();
      step();
      step();
      checkValue("inflight_before_reset", 64'(inflight), 64'd2);
      rst_n = 1'b0;
      modelReset();
      for (int i = 0; i < NUM_REQ; i++) valid_q[i] = 1'b0;
      applyStimulus();
      step();
      rst_n      = 1'b1;
      m_drain    = L + 1;
      valid_q[2] = 1'b1;
      hold_a[2]  = randOp();
      hold_b[2]  = randOp();
      applyStimulus();
      blocked = 0;
      got     = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
         inject = (m_drain > 0);
         step();
         if (last_rdy != '0) got = 1'b1;
         else blocked++;
      end
      inject = 1'b0;
      checkValue("redrain_blocked_cycles", 64'(blocked), 64'(L + 1));
      checkValue("redrain_grant", 64'(last_rdy), 64'b0100);
      repeat (L + 3) step();
      checkValue("reset_queue_empty", 64'(exp_q.size()), 64'd0);
      checkValue("err_after_reset", 64'(last_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
